hack_cpu_ctrl: RTL and testbench
================================

// Module: hack_cpu_ctrl
// PURPOSE
// - Control/sequencing end of the Hack ALU interface: fetches Hack instructions, decodes them,
//   drives the external ALU (x, y, zx, nx, zy, ny, f, no) and consumes its results (out, zr, ng).
// - Owns the A, D and PC registers. Sits between the instruction ROM, the data RAM and the ALU
//   to form the Hack CPU.
// PARAMETERS
// - PC_W      15      width of PC / instruction address (32K-word ROM)
// - RESET_PC  0       PC value loaded on reset
// PORTS
// - clk        in   1     single clock, all state updates on rising edge
// - rst_n      in   1     asynchronous active-low reset
// - imem_req   out  1     fetch request, high while in FETCH
// - imem_addr  out  PC_W  instruction address (= pc)
// - imem_ack   in   1     instruction valid this cycle
// - imem_data  in   16    instruction word
// - in_m       in   16    RAM[address_m], combinational from data RAM
// - out_m      out  16    write data (= alu_out)
// - address_m  out  15    data address (= A[14:0])
// - write_m    out  1     one-cycle RAM write strobe
// - alu_x      out  16    ALU x operand (= D)
// - alu_y      out  16    ALU y operand (a-bit ? in_m : A)
// - alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out 1 each  = ir[11:6] in that order
// - alu_out    in   16    ALU result
// - alu_zr     in   1     alu_out == 0
// - alu_ng     in   1     alu_out[15]
// - pc         out  PC_W  current program counter
// - trap       out  1     illegal-instruction halt flag (HACK_ILLEGAL_TRAP_EN only, else tied 0)
// BEHAVIOUR
// - Reset (async, rst_n=0): pc=RESET_PC; A=0; D=0; ir=0; state=FETCH; write_m=0; trap=0.
//   A reset asserted mid-instruction abandons it; no register or RAM write completes.
// - FSM states: FETCH, EXEC (and HALT when the trap feature is compiled in).
// - FETCH: imem_req=1. On imem_ack, latch ir<=imem_data and go to EXEC; otherwise stay.
//   No A/D/PC change while waiting.
// - EXEC (exactly one cycle), then back to FETCH. Minimum 2 cycles per instruction.
//   - A-instruction (ir[15]=0): A<=ir; pc<=pc+1; write_m=0.
//   - C-instruction (ir[15]=1): the ALU is driven from ir. dest ir[5:3] = {A,D,M}.
//     A<=alu_out if d1; D<=alu_out if d2; write_m=1 for this cycle if d3.
// - ALU control outputs hold ir[11:6] in every state. Their value is only meaningful in EXEC.
// - Jump on j=ir[2:0]: take = (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr).
//   If taken, pc<=A_old[PC_W-1:0]; else pc<=pc+1.
// - Simultaneous updates:
//   - address_m and the jump target use A before this instruction's update (A_old).
//   - With dest AM, the RAM write goes to A_old and A takes alu_out.
// - PC wraps modulo 2^PC_W: pc at all ones plus 1 gives 0.
// - The a-bit (ir[12]) selects in_m over A for alu_y. in_m is sampled in EXEC.
// CONFIGURATION
// - HACK_ILLEGAL_TRAP_EN defined:
//   - A C-instruction with ir[14:13]!=2'b11 enters HALT: no register writes, write_m=0, trap=1.
//   - HALT is left only by reset.
// - Not defined: ir[14:13] are ignored (standard Hack); trap is constant 0; no HALT state.
// STRUCTURE
// - Shared package hack_pkg: WORD_W=16; typedef word_t; typedef enum cpu_state_t
//   {FETCH, EXEC, HALT}; localparams for ir bit positions (A_BIT=12, CTRL_LSB=6, DEST_LSB=3,
//   JMP_LSB=0).
// - One sub-module: hack_jump_unit (combinational j, zr, ng -> take).
//   The ALU itself stays external.
// TESTING
// - Reset mid-EXEC of M=D: rst_n low -> write_m drops immediately, pc=0, A=0, D=0; next fetch
//   is at addr 0.
// - @17 (0x0011), then D=A (0xEC10): ALU ctrl=110000 with alu_y=0x0011, so D=0x0011 and pc=2.
// - @3, then D=D+A (0xE090) with D=0x0011: ctrl=000010, so D=0x0014.
// - @5, then M=D (0xE308) with D=0x0014: write_m high exactly 1 cycle with address_m=5,
//   out_m=0x0014.
// - @16, D;JGT (0xE301): D=1 -> pc=0x10; D=0 -> pc+1.
//   @16, 0;JMP (0xEA87) -> pc=0x10.
// - imem_ack low for 3 cycles: stays in FETCH with imem_req=1 and no state change.
//   With HACK_ILLEGAL_TRAP_EN, 0x8000 -> trap=1, pc frozen, no writes until reset.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types and instruction-field positions for the Hack CPU control block.
// HACK_ILLEGAL_TRAP_EN enables trapping on C-instructions whose bits 14:13 are not 2'b11.
package hack_pkg;

  localparam int WORD_W   = 16;
  localparam int CI_BIT   = 15;
  localparam int A_BIT    = 12;
  localparam int CTRL_LSB = 6;
  localparam int DEST_LSB = 3;
  localparam int JMP_LSB  = 0;

`ifdef HACK_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } cpu_state_t;

  // Without the trap feature every C-instruction is legal, so bits 14:13 are ignored.
  function automatic logic c_legal(word_t instr);
    return (instr[14:13] == 2'b11) || !TRAP_EN;
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_if.sv
// Bus bundle between the Hack CPU control block and its ROM, RAM and external ALU.
// master = CPU control side, slave = memories/ALU side.
interface hack_cpu_ctrl_if #(
  parameter int PC_W = 15
);
  import hack_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  word_t           imem_data;

  word_t           in_m;
  word_t           out_m;
  logic [14:0]     address_m;
  logic            write_m;

  word_t           alu_x;
  word_t           alu_y;
  logic            alu_zx;
  logic            alu_nx;
  logic            alu_zy;
  logic            alu_ny;
  logic            alu_f;
  logic            alu_no;
  word_t           alu_out;
  logic            alu_zr;
  logic            alu_ng;

  modport master (
    output imem_req, imem_addr, out_m, address_m, write_m,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  imem_ack, imem_data, in_m, alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  imem_req, imem_addr, out_m, address_m, write_m,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output imem_ack, imem_data, in_m, alu_out, alu_zr, alu_ng
  );

endinterface

// File: rtl/hack_jump_unit.sv
// Hack jump condition: decides from j[2:0] and the ALU flags whether a C-instruction branches.
module hack_jump_unit (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/sequencing: fetch, decode, drive the external ALU, own A/D/PC.
// HACK_ILLEGAL_TRAP_EN adds the HALT state and the trap output.
//
//   state | meaning
//   FETCH | imem_req high, wait for imem_ack, latch instruction into ir
//   EXEC  | one cycle: update A/D/PC, pulse write_m if dest M
//   HALT  | illegal C-instruction seen; frozen until reset (trap build only)
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int              PC_W     = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  hack_cpu_ctrl_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic            trap
);

  cpu_state_t      state_q, state_d;
  word_t           ir_q, ir_d;
  word_t           a_q, a_d;
  word_t           d_q, d_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            write_m_q, write_m_d;
  logic            imem_req_q, imem_req_d;
  logic            trap_q, trap_d;
  logic            take;
  logic [2:0]      dest;
  logic [PC_W-1:0] pc_inc;

  assign dest   = ir_q[DEST_LSB +: 3];
  assign pc_inc = pc_q + PC_W'(1);

  hack_jump_unit u_jump (
    .j    (ir_q[JMP_LSB +: 3]),
    .zr   (bus.alu_zr),
    .ng   (bus.alu_ng),
    .take (take)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    a_d        = a_q;
    d_d        = d_q;
    pc_d       = pc_q;
    write_m_d  = 1'b0;
    imem_req_d = imem_req_q;
    trap_d     = trap_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          ir_d       = bus.imem_data;
          state_d    = EXEC;
          imem_req_d = 1'b0;
          // write_m is registered, so the dest-M strobe is decided at fetch time
          write_m_d  = bus.imem_data[CI_BIT] & bus.imem_data[DEST_LSB] & c_legal(bus.imem_data);
        end
      end
      EXEC: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
        if (!ir_q[CI_BIT]) begin
          a_d  = ir_q;
          pc_d = pc_inc;
        end else if (!c_legal(ir_q)) begin
          state_d    = HALT;
          imem_req_d = 1'b0;
          trap_d     = 1'b1;
        end else begin
          if (dest[2]) a_d = bus.alu_out;
          if (dest[1]) d_d = bus.alu_out;
          pc_d = take ? a_q[PC_W-1:0] : pc_inc;
        end
      end
      HALT: begin
        state_d    = HALT;
        imem_req_d = 1'b0;
      end
      default: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      ir_q       <= '0;
      a_q        <= '0;
      d_q        <= '0;
      pc_q       <= RESET_PC;
      write_m_q  <= 1'b0;
      imem_req_q <= 1'b1;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      d_q        <= d_d;
      pc_q       <= pc_d;
      write_m_q  <= write_m_d;
      imem_req_q <= imem_req_d;
      trap_q     <= trap_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.out_m     = bus.alu_out;
  assign bus.address_m = a_q[14:0];
  assign bus.write_m   = write_m_q;
  assign bus.alu_x     = d_q;
  assign bus.alu_y     = ir_q[A_BIT] ? bus.in_m : a_q;
  assign bus.alu_zx    = ir_q[CTRL_LSB+5];
  assign bus.alu_nx    = ir_q[CTRL_LSB+4];
  assign bus.alu_zy    = ir_q[CTRL_LSB+3];
  assign bus.alu_ny    = ir_q[CTRL_LSB+2];
  assign bus.alu_f     = ir_q[CTRL_LSB+1];
  assign bus.alu_no    = ir_q[CTRL_LSB];
  assign pc            = pc_q;

`ifdef HACK_ILLEGAL_TRAP_EN
  assign trap = trap_q;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboard bench for hack_cpu_ctrl: bench supplies ROM handshake, RAM and a Hack ALU.
module tb_hack_cpu_ctrl;

  localparam int PC_W = 15;

  typedef struct {
    logic [15:0] instr;
    logic [14:0] pc;
    logic [15:0] d;
    logic [15:0] a;
    logic        wr;
    logic [14:0] waddr;
    logic [15:0] wdata;
    logic        chk_y;
    logic [15:0] y;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [PC_W-1:0] pc;
  logic            trap;
  logic            ram_clr;
  logic [15:0]     ram [64];
  logic [14:0]     exp_fetch;
  logic            in_exec;
  exp_t            sb [$];
  int              n_tests;
  int              n_fail;

  hack_cpu_ctrl_if #(.PC_W(PC_W)) bus ();

  hack_cpu_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .pc    (pc),
    .trap  (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(logic [15:0] x, logic [15:0] y, logic [5:0] c);
    logic [15:0] o;
    if (c[5]) x = '0;
    if (c[4]) x = ~x;
    if (c[3]) y = '0;
    if (c[2]) y = ~y;
    o = c[1] ? (x + y) : (x & y);
    if (c[0]) o = ~o;
    return o;
  endfunction

  always_comb begin
    bus.alu_out = hack_alu(bus.alu_x, bus.alu_y,
                           {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no});
    bus.alu_zr  = (bus.alu_out == 16'h0000);
    bus.alu_ng  = bus.alu_out[15];
    bus.in_m    = ram[bus.address_m[5:0]];
  end

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (bus.write_m) begin
      ram[bus.address_m[5:0]] <= bus.out_m;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: EXEC cycle is the first negedge with imem_req low, the result is
  // visible at the negedge where imem_req returns high.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_exec = 1'b0;
    end else if (!in_exec && !bus.imem_req && sb.size() > 0) begin
      in_exec = 1'b1;
      chk("exec_write_m", 32'(bus.write_m), 32'(sb[0].wr));
      chk("exec_ctrl", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}),
          32'(sb[0].instr[11:6]));
      if (sb[0].wr) begin
        chk("exec_address_m", 32'(bus.address_m), 32'(sb[0].waddr));
        chk("exec_out_m", 32'(bus.out_m), 32'(sb[0].wdata));
      end
      if (sb[0].chk_y) chk("exec_alu_y", 32'(bus.alu_y), 32'(sb[0].y));
    end else if (in_exec && bus.imem_req && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      in_exec = 1'b0;
      chk("pc", 32'(pc), 32'(e.pc));
      chk("d_reg", 32'(bus.alu_x), 32'(e.d));
      chk("a_reg", 32'(bus.address_m), 32'(e.a[14:0]));
      chk("write_m_idle", 32'(bus.write_m), 32'd0);
      chk("trap_idle", 32'(trap), 32'd0);
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req && !in_exec) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("fetch_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [15:0] instr, input logic [14:0] epc, input logic [15:0] ed,
                       input logic [15:0] ea, input logic wr = 1'b0,
                       input logic [14:0] waddr = '0, input logic [15:0] wdata = '0,
                       input logic chk_y = 1'b0, input logic [15:0] y = '0);
    bit   ok;
    exp_t e;
    wait_req(ok);
    if (!ok) return;
    chk("fetch_addr", 32'(bus.imem_addr), 32'(exp_fetch));
    e = '{instr, epc, ed, ea, wr, waddr, wdata, chk_y, y};
    sb.push_back(e);
    exp_fetch     = epc;
    bus.imem_data = instr;
    bus.imem_ack  = 1'b1;
    @(posedge clk);
    #1 bus.imem_ack = 1'b0;
  endtask

  initial begin
    bit ok;
    n_tests       = 0;
    n_fail        = 0;
    in_exec       = 1'b0;
    exp_fetch     = '0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    ram_clr       = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_a", 32'(bus.address_m), 32'd0);
    chk("rst_d", 32'(bus.alu_x), 32'd0);
    chk("rst_write_m", 32'(bus.write_m), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
    chk("rst_trap", 32'(trap), 32'd0);
    @(negedge clk);
    ram_clr = 1'b0;
    rst_n   = 1'b1;

    issue(16'h0011, 15'h0001, 16'h0000, 16'h0011);
    issue(16'hEC10, 15'h0002, 16'h0011, 16'h0011, 1'b0, '0, '0, 1'b1, 16'h0011);
    issue(16'h0003, 15'h0003, 16'h0011, 16'h0003);
    issue(16'hE090, 15'h0004, 16'h0014, 16'h0003, 1'b0, '0, '0, 1'b1, 16'h0003);
    issue(16'h0005, 15'h0005, 16'h0014, 16'h0005);
    issue(16'hE308, 15'h0006, 16'h0014, 16'h0005, 1'b1, 15'h0005, 16'h0014);
    issue(16'h0001, 15'h0007, 16'h0014, 16'h0001);
    issue(16'hEC10, 15'h0008, 16'h0001, 16'h0001);
    issue(16'h0010, 15'h0009, 16'h0001, 16'h0010);
    issue(16'hE301, 15'h0010, 16'h0001, 16'h0010);
    issue(16'hEA90, 15'h0011, 16'h0000, 16'h0010);
    issue(16'h0010, 15'h0012, 16'h0000, 16'h0010);
    issue(16'hE301, 15'h0013, 16'h0000, 16'h0010);
    issue(16'hEA87, 15'h0010, 16'h0000, 16'h0010);
    issue(16'h0005, 15'h0011, 16'h0000, 16'h0005);
    issue(16'hFC10, 15'h0012, 16'h0014, 16'h0005, 1'b0, '0, '0, 1'b1, 16'h0014);
    issue(16'hE328, 15'h0013, 16'h0014, 16'h0014, 1'b1, 15'h0005, 16'h0014);
    issue(16'h7FFF, 15'h0014, 16'h0014, 16'h7FFF);
    issue(16'hEA87, 15'h7FFF, 16'h0014, 16'h7FFF);
    issue(16'h0002, 15'h0000, 16'h0014, 16'h0002);

    // ROM not acknowledging: FETCH must hold with no state change
    wait_req(ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req", 32'(bus.imem_req), 32'd1);
      chk("stall_pc", 32'(pc), 32'd0);
      chk("stall_a", 32'(bus.address_m), 32'd2);
    end

    // Reset in the middle of an EXEC that would write RAM
    issue(16'h0007, 15'h0001, 16'h0014, 16'h0007);
    issue(16'hE308, 15'h0002, 16'h0014, 16'h0007, 1'b1, 15'h0007, 16'h0014);
    chk("pre_rst_write_m", 32'(bus.write_m), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_write_m", 32'(bus.write_m), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_a", 32'(bus.address_m), 32'd0);
    chk("midrst_d", 32'(bus.alu_x), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_ram", 32'(ram[7]), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_fetch = '0;
    issue(16'h0011, 15'h0001, 16'h0000, 16'h0011);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);

`ifdef HACK_ILLEGAL_TRAP_EN
    wait_req(ok);
    bus.imem_data = 16'h8000;
    bus.imem_ack  = 1'b1;
    @(posedge clk);
    #1 bus.imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("trap_set", 32'(trap), 32'd1);
    chk("trap_req", 32'(bus.imem_req), 32'd0);
    chk("trap_pc", 32'(pc), 32'd1);
    chk("trap_write_m", 32'(bus.write_m), 32'd0);
    chk("trap_d", 32'(bus.alu_x), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("trap_clr", 32'(trap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
